// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the fetch front end.
//   fq_entry_t  : one buffered fetch result {pc, instr} at the default 32-bit width
//   PC_STEP     : byte distance between consecutive instruction words
//   align_word  : clears the two low address bits so a target lands on a word boundary
// Enable the same-cycle response bypass in fetch_queue by defining FETCH_BYPASS_EN.
package fetch_pkg;

    localparam int unsigned FQ_XLEN = 32;
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
    } fq_entry_t;

    // Operates on a 64-bit container so any XLEN up to 64 can use it through casts.
    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return addr & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_queue_ring.sv
// fq_ring: DEPTH-entry circular buffer of {pc, instr} pairs.
// Ports:
//   clk, reset            : clock and asynchronous active-high reset
//   flush                 : empties the buffer (wins over push and pop)
//   push, push_pc/instr   : write one entry at the tail
//   pop                   : drop the head entry (caller only pops when count > 0)
//   count                 : number of entries held, 0..DEPTH
//   head_pc, head_instr   : contents of the head entry (meaningless when count == 0)
module fq_ring
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr
);

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            write_en;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        write_en = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            write_en = push;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed after it has been written.
    always_ff @(posedge clk) begin
        if (write_en) begin
            pc_mem_q[wr_ptr_q]    <= push_pc;
            instr_mem_q[wr_ptr_q] <= push_instr;
        end
    end

    assign count      = count_q;
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction fetch front end.
// Issues in-order word requests to instruction memory (valid/grant), buffers the
// returned words with their PCs in a DEPTH-entry ring, and hands them to decode
// through a valid/ready pair. A redirect flushes the ring and marks every request
// still in flight as stale so its response is thrown away.
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   imem_req/imem_addr/imem_gnt        : request channel to instruction memory
//   imem_rvalid/imem_rdata             : in-order response channel
//   redirect/redirect_pc               : taken branch or jump from decode
//   validD/readyD/instrD/pcD/pcplus4D  : head instruction towards decode
// Build option: FETCH_BYPASS_EN lets a response reach decode in the cycle it
// arrives when the ring is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            validD,
    input  logic            readyD,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcplus4D
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 2;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   pend_q, pend_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count;
    logic [SW-1:0]   inflight;
    logic            grant;
    logic            resp_valid, resp_drop, resp_live;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] head_pc, head_instr;
    logic            bypass_hit;
    logic            ring_push, ring_pop;

    // Credit rule: buffered + live + stale never exceeds DEPTH, so every response
    // that arrives has a slot waiting. The sum depends only on registered state,
    // keeping readyD off the path to imem_req.
    assign inflight  = SW'(count) + SW'(pend_q) + SW'(drop_q);
    assign imem_req  = !reset && !redirect && (inflight < SW'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;

    assign resp_valid = imem_rvalid && !reset;
    assign resp_drop  = resp_valid && (drop_q != '0);
    assign resp_live  = resp_valid && (drop_q == '0);

    // Live requests are contiguous words ending just below fetch_pc, so the
    // oldest one sits pend words behind it.
    assign resp_pc = fetch_pc_q - (XLEN'(pend_q) * XLEN'(PC_STEP));

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = resp_live && (count == '0) && !redirect;
`else
    assign bypass_hit = 1'b0;
`endif

    // Decode sees the bypassed response when it is the only data available,
    // otherwise the ring head; everything reads as zero while nothing is valid.
    always_comb begin
        validD   = 1'b0;
        instrD   = '0;
        pcD      = '0;
        pcplus4D = '0;
        if (bypass_hit) begin
            validD = 1'b1;
            instrD = imem_rdata;
            pcD    = resp_pc;
        end else if (count != '0) begin
            validD = 1'b1;
            instrD = head_instr;
            pcD    = head_pc;
        end
        if (validD) pcplus4D = pcD + XLEN'(PC_STEP);
    end

    // A redirect kills the head too, so neither push nor pop happens that cycle.
    // A bypassed word consumed by decode never enters the ring.
    assign ring_pop  = validD && readyD && !redirect && !bypass_hit;
    assign ring_push = resp_live && !redirect && !(bypass_hit && readyD);

    // On redirect every live request turns stale; a response landing in the
    // same cycle retires one of them (stale or live) immediately.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        if (redirect) begin
            fetch_pc_d = XLEN'(align_word(64'(redirect_pc)));
            drop_d     = drop_q + pend_q - CW'(resp_valid);
            pend_d     = '0;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            pend_d = pend_q + CW'(grant) - CW'(resp_live);
            drop_d = drop_q - CW'(resp_drop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            pend_q     <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
        end
    end

    fq_ring #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (ring_push),
        .push_pc    (resp_pc),
        .push_instr (imem_rdata),
        .pop        (ring_pop),
        .count      (count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch front end for the pipelined core. It replaces the single PC register and the F/D instruction register with a DEPTH-entry prefetch queue.
- Issues in-order instruction-memory requests under a valid/grant handshake with variable response latency.
- Buffers returned words with their PCs and presents them to decode through a valid/ready interface.
- Handles branch/jump redirects by flushing the queue and discarding responses still in flight.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 4, queue entries; power of two, at least 2. Also the limit on requests outstanding plus entries held.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request address, word aligned.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  XLEN  response instruction word.
- redirect  in  1  decode-stage branch taken or jump.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
- validD  out  1  instrD/pcD hold a valid instruction.
- readyD  in  1  decode consumes the head entry (drive from ~stallD).
- instrD  out  XLEN  head instruction.
- pcD  out  XLEN  head PC.
- pcplus4D  out  XLEN  pcD + 4, modulo 2^XLEN.

Behaviour:
- State:
  - fetch_pc: next address to request.
  - Circular queue of {pc, instr} with rd_ptr, wr_ptr and count (0..DEPTH).
  - pend: live requests outstanding.
  - drop: stale requests whose responses must be discarded.
  - pend + drop never exceeds DEPTH.
- Reset (asynchronous, takes effect immediately, allowed mid-operation): fetch_pc=RESET_PC; count=pend=drop=0; pointers=0; imem_req=0; validD=0; instrD, pcD, pcplus4D=0. In-flight memory responses at reset are the memory's responsibility; this block ignores imem_rvalid while reset is high.
- Issue:
  - imem_req = !reset && !redirect && (count + pend + drop < DEPTH).
  - imem_addr = fetch_pc.
  - On imem_req && imem_gnt: fetch_pc += 4 (wraps modulo 2^XLEN) and pend++.
  - imem_req and imem_addr are held stable until granted.
- Response:
  - If drop > 0, the response is discarded and drop--.
  - Otherwise it is pushed as {pc of oldest live request, imem_rdata}, then pend-- and count++.
  - PCs of live requests are derived from the head-of-queue PC plus count/pend arithmetic or a small PC FIFO; either implementation is acceptable.
  - Overflow cannot occur because of the credit rule.
- Output:
  - validD = (count > 0); instrD and pcD come from the rd_ptr entry.
  - Pop when validD && readyD.
  - Push and pop in the same cycle leave count unchanged, and the pointers wrap at DEPTH.
  - With readyD=0, outputs hold stable.
- Redirect (highest priority):
  - In the cycle redirect=1, no request is issued and any pop is ignored; the head entry is killed with the rest of the queue.
  - Next edge: count=0, pointers unchanged or reset (implementation choice), fetch_pc={redirect_pc[XLEN-1:2],2'b00}, drop=drop+pend-(response arriving this cycle ? 1:0), pend=0.
  - First new request issues the cycle after redirect.
  - Back-to-back redirects are legal; the last one wins.
- Latency: with a 1-cycle memory, always-granted and readyD=1, the first validD comes 2 cycles after reset release, followed by a sustained 1 instruction per cycle.
- Must not generate combinational paths from readyD to imem_req, except through the FETCH_BYPASS_EN path.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When count==0, drop==0 and a live response arrives, validD=1 in the same cycle with instrD=imem_rdata and pcD=its PC.
  - If readyD=1 it is consumed and not written; otherwise it is written.
  - Saves one cycle of latency.
- Undefined: responses always enter the queue first, so data is visible one cycle after imem_rvalid.

Decomposition:
- Package fetch_pkg:
  - typedef fq_entry_t {pc, instr}.
  - Localparam PC_STEP=4.
  - Function for aligning the redirect target.
- One natural sub-module: fq_ring (DEPTH x entry circular buffer with push, pop, flush, count). The top module holds the issue, credit and drop logic.

Test Plan:
- Reset release, 1-cycle memory, gnt=1, readyD=1 -> pcD sequence 0x0,0x4,0x8,... one per cycle, first validD 2 cycles after reset falls.
- readyD=0 for 10 cycles, DEPTH=4 -> exactly 4 entries held, imem_req=0 once count+pend=4, outputs stable; readyD=1 drains pcD 0x0..0xC in order.
- 3-cycle response latency, gnt toggling 1/0 -> no entry lost or duplicated; pcD strictly +4 per pop.
- redirect with redirect_pc=0x1003 while pend=2, count=2 -> next validD shows pcD=0x1000; both stale responses dropped; no old PC ever visible.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0, and pcplus4D of that entry is 0x0.
- Reset asserted mid-stream with responses pending -> validD=0 immediately; after release fetching restarts at RESET_PC. With FETCH_BYPASS_EN, the first instruction appears in the same cycle as imem_rvalid.
